// File: rtl/rr_arb_pkg.sv
// Shared definitions for the round-robin lock arbiter: FSM state encoding
// and the default watchdog limit.
package rr_arb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  // Cycles the granted requester may hold its request low before the
  // watchdog forces the lock open.
  localparam int DEFAULT_TIMEOUT = 16;

endpackage : rr_arb_pkg

// File: rtl/rr_pick.sv
// Combinational rotating-priority selector. Returns the first index at or
// after ptr (wrapping modulo N) whose request is set and not masked.
module rr_pick #(
  parameter  int N     = 10,
  localparam int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [N-1:0]     mask,
  input  logic [IDX_W-1:0] ptr,
  output logic             found,
  output logic [IDX_W-1:0] idx
);

  logic [N-1:0]     eligible;
  int               pos;
  logic [IDX_W-1:0] pos_idx;

  assign eligible = req & ~mask;

  // Scan from the farthest offset back toward ptr so the nearest eligible
  // index is the one left standing when the loop ends.
  always_comb begin
    // NOTE: every output gets a default before the loop so no path through
    // this block can leave a value unassigned and infer a latch.
    found   = 1'b0;
    idx     = '0;
    pos     = 0;
    pos_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      pos = int'(ptr) + i;
      if (pos >= N) begin
        pos = pos - N;
      end
      pos_idx = IDX_W'(pos);
      if (eligible[pos_idx]) begin
        found = 1'b1;
        idx   = pos_idx;
      end
    end
  end

endmodule : rr_pick

// File: rtl/rr_lock_arbiter.sv
// Round-robin arbiter that locks the shared target to one requester for a
// whole multi-beat transaction. The lock opens on an accepted last beat or
// when the watchdog sees the owner idle for TIMEOUT consecutive cycles; on
// release the grant moves straight to the next requester with no bubble,
// excluding the one that just finished.
module rr_lock_arbiter
  import rr_arb_pkg::*;
#(
  parameter  int N       = 10,
  parameter  int TIMEOUT = DEFAULT_TIMEOUT,
  localparam int IDX_W   = $clog2(N),
  localparam int TO_W    = $clog2(TIMEOUT + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [N-1:0]     i_req,
  input  logic [N-1:0]     i_last,
  input  logic             i_ready,
  output logic [N-1:0]     o_grant,
  output logic [IDX_W-1:0] o_grant_idx,
  output logic             o_valid,
  output logic             o_busy,
  output logic             o_timeout
);

  arb_state_e       state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [N-1:0]     grant_q, grant_d;
  logic [IDX_W-1:0] grant_idx_q, grant_idx_d;
  logic [TO_W-1:0]  wdog_q, wdog_d;
  logic             timeout_q, timeout_d;

  logic             owner_req;
  logic             owner_last;
  logic [IDX_W-1:0] rel_ptr;
  logic [IDX_W-1:0] pick_ptr;
  logic [N-1:0]     pick_mask;
  logic             pick_found;
  logic [IDX_W-1:0] pick_idx;
  logic             release_beat;
  logic             release_to;

  // Owner's request/last and the pointer it would hand over on release.
  always_comb begin
    owner_req  = i_req[grant_idx_q];
    owner_last = i_last[grant_idx_q];
    rel_ptr    = (grant_idx_q == IDX_W'(N - 1)) ? '0 : grant_idx_q + 1'b1;
  end

  // While locked, the selector looks ahead from the post-release pointer
  // with the current owner masked out; while idle it scans everyone from ptr.
  always_comb begin
    if (state_q == LOCKED) begin
      pick_ptr  = rel_ptr;
      pick_mask = N'(1) << grant_idx_q;
    end else begin
      pick_ptr  = ptr_q;
      pick_mask = '0;
    end
  end

  rr_pick #(
    .N (N)
  ) u_pick (
    .req   (i_req),
    .mask  (pick_mask),
    .ptr   (pick_ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // Next-state logic: arbitration from IDLE, lock hold, watchdog and release.
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    grant_d      = grant_q;
    grant_idx_d  = grant_idx_q;
    wdog_d       = wdog_q;
    timeout_d    = 1'b0;
    release_beat = 1'b0;
    release_to   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d     = LOCKED;
          grant_d     = N'(1) << pick_idx;
          grant_idx_d = pick_idx;
          wdog_d      = '0;
        end
      end

      LOCKED: begin
        // An accepted last beat implies the owner's request is high, so it
        // always wins over a watchdog expiry in the same cycle.
        if (owner_req && i_ready && owner_last) begin
          release_beat = 1'b1;
        end else if (!owner_req) begin
          if (wdog_q >= TO_W'(TIMEOUT - 1)) begin
            release_to = 1'b1;
          end else begin
            wdog_d = wdog_q + 1'b1;
          end
        end else begin
          wdog_d = '0;
        end

        if (release_beat || release_to) begin
          timeout_d = release_to;
          ptr_d     = rel_ptr;
          wdog_d    = '0;
          if (pick_found) begin
            grant_d     = N'(1) << pick_idx;
            grant_idx_d = pick_idx;
          end else begin
            state_d     = IDLE;
            grant_d     = '0;
            grant_idx_d = '0;
          end
        end
      end

      default: begin
        state_d     = IDLE;
        grant_d     = '0;
        grant_idx_d = '0;
      end
    endcase
  end

  // State registers with synchronous reset; reset drops any grant at once.
  always_ff @(posedge i_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (i_rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      grant_q     <= '0;
      grant_idx_q <= '0;
      wdog_q      <= '0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      grant_q     <= grant_d;
      grant_idx_q <= grant_idx_d;
      wdog_q      <= wdog_d;
      timeout_q   <= timeout_d;
    end
  end

  assign o_grant     = grant_q;
  assign o_grant_idx = grant_idx_q;
  assign o_busy      = (state_q == LOCKED);
  assign o_timeout   = timeout_q;
  assign o_valid     = o_busy & i_req[grant_idx_q];

endmodule : rr_lock_arbiter
